// File: rtl/exec_ctrl_pkg.sv
// Shared types and constants for the execution controller.
package exec_ctrl_pkg;

    // Encodings are visible on the state output, so they are pinned explicitly.
    typedef enum logic [1:0] {
        S_PAUSED = 2'd0,
        S_STEP   = 2'd1,
        S_RUN    = 2'd2,
        S_HALTED = 2'd3
    } exec_state_t;

    localparam logic [31:0] EBREAK_INSN = 32'h00100073;

endpackage

// File: rtl/button_debouncer.sv
// Push-button conditioning: 2-FF synchronizer, stability counter and
// rising-edge pulse on the accepted level.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_level,
    output logic rise_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          rise_q, rise_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Count consecutive cycles the synchronized input disagrees with the accepted level.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        level_d = level_q;
        rise_d  = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
                rise_d  = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchronizer, stability counter and edge pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign btn_level  = level_q;
    assign rise_pulse = rise_q;

endmodule

// File: rtl/exec_controller.sv
// Execution sequencer for the single-cycle core: single-step, divided free-run,
// and stop on PC breakpoint or EBREAK. Issues a registered one-cycle cpu_en.
module exec_controller
    import exec_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RUN_DIV         = 12500000,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step_btn,
    input  logic             run_sw,
    input  logic             break_en,
    input  logic [31:0]      break_pc,
    input  logic [31:0]      pc_current,
    input  logic [31:0]      instruction,
    output logic             cpu_en,
    output logic [1:0]       state,
    output logic             halted,
    output logic [CNT_W-1:0] step_count
);

    localparam int DIV_W = $clog2(RUN_DIV);

    exec_state_t      state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             skip_bp_q, skip_bp_d;
    logic             cpu_en_q, cpu_en_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic btn_level;
    logic btn_rise;
    logic step_req;
    logic is_ebreak;
    logic div_tc;
    logic bp_hit;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk       (clk),
        .reset     (reset),
        .btn_raw   (step_btn),
        .btn_level (btn_level),
        .rise_pulse(btn_rise)
    );

    // A rise is only meaningful while the accepted level is high.
    assign step_req  = btn_rise & btn_level;
    assign is_ebreak = (instruction == EBREAK_INSN);
    assign div_tc    = (div_q == DIV_W'(RUN_DIV - 1));
    assign bp_hit    = break_en && (pc_current == break_pc);

    // Next-state, divider, breakpoint-skip and enable decisions.
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        skip_bp_d = skip_bp_q;
        cpu_en_d  = 1'b0;
        cnt_d     = cnt_q;
        case (state_q)
            S_PAUSED: begin
                if (is_ebreak) begin
                    state_d = S_HALTED;
                end else if (run_sw) begin
                    // Skip the breakpoint once so resuming from it makes progress.
                    state_d   = S_RUN;
                    div_d     = '0;
                    skip_bp_d = 1'b1;
                end else if (step_req) begin
                    state_d = S_STEP;
                end
            end
            S_STEP: begin
                if (is_ebreak) begin
                    state_d = S_HALTED;
                end else begin
                    cpu_en_d = 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                    state_d  = S_PAUSED;
                end
            end
            S_RUN: begin
                if (is_ebreak) begin
                    state_d = S_HALTED;
                end else if (!run_sw) begin
                    state_d = S_PAUSED;
                    div_d   = '0;
                end else if (div_tc) begin
                    div_d = '0;
                    if (bp_hit && !skip_bp_q) begin
                        state_d = S_PAUSED;
                    end else begin
                        cpu_en_d  = 1'b1;
                        cnt_d     = cnt_q + 1'b1;
                        skip_bp_d = 1'b0;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_HALTED: begin
                state_d = S_HALTED;
            end
            default: begin
                state_d = S_PAUSED;
            end
        endcase
        halted_d = (state_d == S_HALTED);
    end

    // State, divider, counter and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_PAUSED;
            div_q     <= '0;
            skip_bp_q <= 1'b0;
            cpu_en_q  <= 1'b0;
            halted_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            skip_bp_q <= skip_bp_d;
            cpu_en_q  <= cpu_en_d;
            halted_q  <= halted_d;
            cnt_q     <= cnt_d;
        end
    end

    assign cpu_en     = cpu_en_q;
    assign state      = state_q;
    assign halted     = halted_q;
    assign step_count = cnt_q;

endmodule

// File: tb/tb_exec_controller.sv
// Directed bench for exec_controller (DEBOUNCE_CYCLES=4, RUN_DIV=3, CNT_W=16),
// plus a narrow-counter instance for the step_count wrap.
module tb_exec_controller;

    localparam logic [31:0] NOP    = 32'h00000013;
    localparam logic [31:0] EBREAK = 32'h00100073;

    logic        clk = 1'b0;
    logic        reset;
    logic        step_btn;
    logic        run_sw;
    logic        break_en;
    logic [31:0] break_pc;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        cpu_en;
    logic [1:0]  state;
    logic        halted;
    logic [15:0] step_count;

    logic        run_sw_w;
    logic        cpu_en_w;
    logic [1:0]  state_w;
    logic        halted_w;
    logic [3:0]  step_count_w;

    logic pc_clear;
    logic prev_en = 1'b0;
    int   cyc = 0;
    int   pulses = 0;
    int   pulses_w = 0;
    int   back2back = 0;
    int   last_pulse_cyc = 0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    exec_controller #(
        .DEBOUNCE_CYCLES(4),
        .RUN_DIV        (3),
        .CNT_W          (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .step_btn   (step_btn),
        .run_sw     (run_sw),
        .break_en   (break_en),
        .break_pc   (break_pc),
        .pc_current (pc),
        .instruction(instruction),
        .cpu_en     (cpu_en),
        .state      (state),
        .halted     (halted),
        .step_count (step_count)
    );

    exec_controller #(
        .DEBOUNCE_CYCLES(4),
        .RUN_DIV        (2),
        .CNT_W          (4)
    ) dut_w (
        .clk        (clk),
        .reset      (reset),
        .step_btn   (1'b0),
        .run_sw     (run_sw_w),
        .break_en   (1'b0),
        .break_pc   (32'h0),
        .pc_current (32'h0),
        .instruction(NOP),
        .cpu_en     (cpu_en_w),
        .state      (state_w),
        .halted     (halted_w),
        .step_count (step_count_w)
    );

    // Core model: the PC advances by one instruction per committed enable.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pc_clear) pc <= 32'h0;
        else if (cpu_en) pc <= pc + 32'd4;
    end

    // Pulse monitor, sampled on the inactive edge.
    always @(negedge clk) begin
        if (cpu_en) begin
            pulses = pulses + 1;
            last_pulse_cyc = cyc;
            if (prev_en) back2back = back2back + 1;
        end
        prev_en = cpu_en;
        if (cpu_en_w) pulses_w = pulses_w + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic apply_reset();
        reset    = 1'b1;
        pc_clear = 1'b1;
        cycles(2);
        reset    = 1'b0;
        cycles(1);
        pc_clear = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got stalled expected finish");
        $fatal(1);
    end

    initial begin
        int bounce [4];
        int p0, pb, t0, lat;
        bit found, seen_run;

        bounce      = '{1, 0, 1, 0};
        reset       = 1'b1;
        pc_clear    = 1'b1;
        step_btn    = 1'b0;
        run_sw      = 1'b0;
        run_sw_w    = 1'b0;
        break_en    = 1'b0;
        break_pc    = 32'h0;
        instruction = NOP;
        cycles(3);

        // Reset state
        check("rst_state",  32'(state), 32'd0);
        check("rst_cpu_en", 32'(cpu_en), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_count",  32'(step_count), 32'd0);
        reset = 1'b0;
        cycles(1);
        pc_clear = 1'b0;
        cycles(1);

        // Bouncy press then a clean hold: exactly one step
        foreach (bounce[i]) begin
            step_btn = bounce[i][0];
            cycles(1);
        end
        p0 = pulses;
        step_btn = 1'b1;
        t0 = cyc;
        cycles(10);
        step_btn = 1'b0;
        cycles(12);
        check("step_pulses", 32'(pulses - p0), 32'd1);
        lat = last_pulse_cyc - t0;
        check("step_latency_in_window", 32'(lat >= 6 && lat <= 9), 32'd1);
        check("step_count_1", 32'(step_count), 32'd1);
        check("step_state_back", 32'(state), 32'd0);

        // Free run for 30 cycles
        p0 = pulses;
        run_sw = 1'b1;
        cycles(30);
        check("run_pulse_count", 32'((pulses - p0) >= 9 && (pulses - p0) <= 11), 32'd1);
        pb = pulses;
        found = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cycles(1);
            if (pulses != pb) begin
                found = 1'b1;
                break;
            end
        end
        check("run_next_pulse_seen", 32'(found), 32'd1);
        // Two cycles after a pulse the divider sits at its terminal count.
        cycles(2);
        run_sw = 1'b0;
        pb = pulses;
        cycles(1);
        check("drop_tc_cpu_en", 32'(cpu_en), 32'd0);
        check("drop_tc_state", 32'(state), 32'd0);
        cycles(3);
        check("drop_tc_no_pulse", 32'(pulses - pb), 32'd0);

        // Breakpoint at 0x0C
        apply_reset();
        break_en = 1'b1;
        break_pc = 32'h0000000C;
        run_sw   = 1'b1;
        found    = 1'b0;
        seen_run = 1'b0;
        for (int k = 0; k < 40; k++) begin
            cycles(1);
            if (state == 2'd2) seen_run = 1'b1;
            else if (seen_run && state == 2'd0) begin
                run_sw = 1'b0;
                found  = 1'b1;
                break;
            end
        end
        check("bp_stopped", 32'(found), 32'd1);
        check("bp_count_3", 32'(step_count), 32'd3);
        check("bp_pc", pc, 32'h0000000C);
        cycles(2);
        check("bp_stays_paused", 32'(state), 32'd0);
        run_sw = 1'b1;
        cycles(5);
        check("bp_resume_count_4", 32'(step_count), 32'd4);
        check("bp_resume_pc", pc, 32'h00000010);
        run_sw   = 1'b0;
        break_en = 1'b0;
        cycles(2);

        // EBREAK while running
        run_sw = 1'b1;
        cycles(2);
        instruction = EBREAK;
        pb = pulses;
        cycles(1);
        check("ebreak_state", 32'(state), 32'd3);
        check("ebreak_halted", 32'(halted), 32'd1);
        for (int k = 0; k < 6; k++) begin
            run_sw = ~run_sw;
            cycles(1);
        end
        step_btn = 1'b1;
        cycles(12);
        step_btn = 1'b0;
        cycles(10);
        check("halt_no_pulse", 32'(pulses - pb), 32'd0);
        check("halt_count_held", 32'(step_count), 32'd4);
        check("halt_state_held", 32'(state), 32'd3);
        run_sw = 1'b0;
        reset  = 1'b1;
        #1;
        check("halt_rst_state", 32'(state), 32'd0);
        check("halt_rst_halted", 32'(halted), 32'd0);
        check("halt_rst_count", 32'(step_count), 32'd0);
        cycles(2);
        reset = 1'b0;
        instruction = NOP;
        cycles(2);

        // Counter wrap on the narrow instance
        run_sw_w = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            cycles(1);
            if (pulses_w == 15) begin
                run_sw_w = 1'b0;
                found = 1'b1;
                break;
            end
        end
        check("wrap_reached_15", 32'(found), 32'd1);
        cycles(1);
        check("wrap_count_15", 32'(step_count_w), 32'd15);
        cycles(2);
        run_sw_w = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cycles(1);
            if (pulses_w == 16) begin
                run_sw_w = 1'b0;
                found = 1'b1;
                break;
            end
        end
        check("wrap_one_more", 32'(found), 32'd1);
        cycles(2);
        check("wrap_count_0", 32'(step_count_w), 32'd0);
        check("wrap_state", 32'(state_w), 32'd0);
        check("wrap_halted", 32'(halted_w), 32'd0);

        // Async reset mid-run
        run_sw = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cycles(1);
            if (cpu_en) begin
                found = 1'b1;
                break;
            end
        end
        check("arst_pulse_seen", 32'(found), 32'd1);
        pb = pulses;
        #1;
        reset = 1'b1;
        #1;
        check("arst_cpu_en_now", 32'(cpu_en), 32'd0);
        check("arst_state_now", 32'(state), 32'd0);
        cycles(2);
        check("arst_cpu_en_after", 32'(cpu_en), 32'd0);
        check("arst_no_pulse", 32'(pulses - pb), 32'd0);
        run_sw = 1'b0;
        reset  = 1'b0;
        cycles(2);

        check("no_back_to_back", 32'(back2back), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
